pe_phase_sequencer: RTL and testbench

PE_PHASE_SEQUENCER -- requirements
Module: pe_phase_sequencer

---
 rtl/pe_phase_sequencer_if.sv | 25 ++
 rtl/pe_phase_sequencer.sv | 150 +++++++++++++++
 tb/tb_pe_phase_sequencer.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/pe_phase_sequencer_if.sv
// Control bundle between a PE phase sequencer and its host: run/abort requests in,
// phase, memory-load and mesh-shift controls out.
interface pe_phase_sequencer_if #(
   parameter int ADDR_WIDTH = 3
);
   logic                  start;
   logic                  halt;
   logic [2:0]            o_phase;
   logic [1:0]            o_dir;
   logic [ADDR_WIDTH-1:0] o_mem_addr;
   logic                  o_mem_we;
   logic                  o_shift_en;
   logic                  o_busy;
   logic                  o_done;

   modport master (
      output start, halt,
      input  o_phase, o_dir, o_mem_addr, o_mem_we, o_shift_en, o_busy, o_done
   );

   modport slave (
      input  start, halt,
      output o_phase, o_dir, o_mem_addr, o_mem_we, o_shift_en, o_busy, o_done
   );
endinterface

// File: rtl/pe_phase_sequencer.sv
// Phase sequencer for a mesh of PEs: LOAD -> SORT -> ROUTE (l,r,u,d) -> COMPUTE -> DONE.
// Every output comes straight from a register; start/halt only affect the next state.
module pe_phase_sequencer #(
   parameter int ADDR_WIDTH     = 3,
   parameter int SORT_CYCLES    = 1,
   parameter int SQRT_N         = 2,
   parameter int COMPUTE_CYCLES = 1
) (
   input logic                clk,
   input logic                rst,
   pe_phase_sequencer_if.slave bus
);

   localparam int SORT_EFF  = (SORT_CYCLES < 1) ? 1 : SORT_CYCLES;
   localparam int COMP_EFF  = (COMPUTE_CYCLES < 1) ? 1 : COMPUTE_CYCLES;
   localparam int ROUTE_EFF = (SQRT_N < 1) ? 1 : SQRT_N;
   localparam int MAX_AB    = (SORT_EFF > COMP_EFF) ? SORT_EFF : COMP_EFF;
   localparam int CNT_MAX   = (MAX_AB > ROUTE_EFF) ? MAX_AB : ROUTE_EFF;
   // The counter only ever holds 0..CNT_MAX-1.
   localparam int CW        = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

   localparam logic [CW-1:0]         SORT_LAST  = CW'(SORT_EFF - 1);
   localparam logic [CW-1:0]         ROUTE_LAST = CW'(ROUTE_EFF - 1);
   localparam logic [CW-1:0]         COMP_LAST  = CW'(COMP_EFF - 1);
   localparam logic [ADDR_WIDTH-1:0] ADDR_LAST  = '1;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      LOAD    = 3'd1,
      SORT    = 3'd2,
      ROUTE   = 3'd3,
      COMPUTE = 3'd4,
      DONE    = 3'd5
   } phase_t;

   phase_t                phase_reg;
   logic [CW-1:0]         cnt_reg;
   logic [1:0]            dir_reg;
   logic [ADDR_WIDTH-1:0] addr_reg;
   logic                  we_reg;
   logic                  shift_reg;
   logic                  busy_reg;
   logic                  done_reg;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         phase_reg <= IDLE;
         cnt_reg   <= '0;
         dir_reg   <= 2'b00;
         addr_reg  <= '0;
         we_reg    <= 1'b0;
         shift_reg <= 1'b0;
         busy_reg  <= 1'b0;
         done_reg  <= 1'b0;
      end else begin
         done_reg <= 1'b0;
         // halt also covers IDLE, so it beats a simultaneous start.
         if (bus.halt) begin
            phase_reg <= IDLE;
            cnt_reg   <= '0;
            dir_reg   <= 2'b00;
            addr_reg  <= '0;
            we_reg    <= 1'b0;
            shift_reg <= 1'b0;
            busy_reg  <= 1'b0;
         end else begin
            case (phase_reg)
               IDLE: begin
                  if (bus.start) begin
                     phase_reg <= LOAD;
                     cnt_reg   <= '0;
                     addr_reg  <= '0;
                     we_reg    <= 1'b1;
                     busy_reg  <= 1'b1;
                  end
               end
               LOAD: begin
                  if (addr_reg == ADDR_LAST) begin
                     phase_reg <= SORT;
                     addr_reg  <= '0;
                     we_reg    <= 1'b0;
                     cnt_reg   <= '0;
                  end else begin
                     addr_reg <= addr_reg + ADDR_WIDTH'(1);
                  end
               end
               SORT: begin
                  if (cnt_reg == SORT_LAST) begin
                     cnt_reg <= '0;
                     if (SQRT_N == 0) begin
                        phase_reg <= COMPUTE;
                     end else begin
                        phase_reg <= ROUTE;
                        dir_reg   <= 2'b00;
                        shift_reg <= 1'b1;
                     end
                  end else begin
                     cnt_reg <= cnt_reg + CW'(1);
                  end
               end
               ROUTE: begin
                  if (cnt_reg == ROUTE_LAST) begin
                     cnt_reg <= '0;
                     if (dir_reg == 2'b11) begin
                        phase_reg <= COMPUTE;
                        dir_reg   <= 2'b00;
                        shift_reg <= 1'b0;
                     end else begin
                        dir_reg <= dir_reg + 2'd1;
                     end
                  end else begin
                     cnt_reg <= cnt_reg + CW'(1);
                  end
               end
               COMPUTE: begin
                  if (cnt_reg == COMP_LAST) begin
                     cnt_reg   <= '0;
                     phase_reg <= DONE;
                     done_reg  <= 1'b1;
                  end else begin
                     cnt_reg <= cnt_reg + CW'(1);
                  end
               end
               DONE: begin
                  phase_reg <= IDLE;
                  busy_reg  <= 1'b0;
               end
               default: begin
                  phase_reg <= IDLE;
                  cnt_reg   <= '0;
                  dir_reg   <= 2'b00;
                  addr_reg  <= '0;
                  we_reg    <= 1'b0;
                  shift_reg <= 1'b0;
                  busy_reg  <= 1'b0;
               end
            endcase
         end
      end
   end

   assign bus.o_phase    = phase_reg;
   assign bus.o_dir      = dir_reg;
   assign bus.o_mem_addr = addr_reg;
   assign bus.o_mem_we   = we_reg;
   assign bus.o_shift_en = shift_reg;
   assign bus.o_busy     = busy_reg;
   assign bus.o_done     = done_reg;

endmodule

// File: tb/tb_pe_phase_sequencer.sv
// Directed bench for pe_phase_sequencer: three parameter sets, full traces, halt,
// async reset, start/halt priority and back-to-back runs.
module tb_pe_phase_sequencer;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   checks = 0;
   int   failures = 0;

   always #5 clk = ~clk;

   logic [2:0] start_v = 3'b000;
   logic [2:0] halt_v  = 3'b000;

   pe_phase_sequencer_if #(.ADDR_WIDTH(3)) bus0 ();
   pe_phase_sequencer_if #(.ADDR_WIDTH(3)) bus1 ();
   pe_phase_sequencer_if #(.ADDR_WIDTH(3)) bus2 ();

   assign bus0.start = start_v[0];
   assign bus0.halt  = halt_v[0];
   assign bus1.start = start_v[1];
   assign bus1.halt  = halt_v[1];
   assign bus2.start = start_v[2];
   assign bus2.halt  = halt_v[2];

   // dut0: defaults; dut1: zero SORT/COMPUTE/SQRT_N; dut2: longer phases
   pe_phase_sequencer #(.ADDR_WIDTH(3), .SORT_CYCLES(1), .SQRT_N(2), .COMPUTE_CYCLES(1))
      dut0 (.clk(clk), .rst(rst), .bus(bus0.slave));
   pe_phase_sequencer #(.ADDR_WIDTH(3), .SORT_CYCLES(0), .SQRT_N(0), .COMPUTE_CYCLES(0))
      dut1 (.clk(clk), .rst(rst), .bus(bus1.slave));
   pe_phase_sequencer #(.ADDR_WIDTH(3), .SORT_CYCLES(3), .SQRT_N(1), .COMPUTE_CYCLES(2))
      dut2 (.clk(clk), .rst(rst), .bus(bus2.slave));

   // {phase[2:0], dir[1:0], addr[2:0], we, shift_en, busy, done}
   logic [11:0] obs0, obs1, obs2;
   assign obs0 = {bus0.o_phase, bus0.o_dir, bus0.o_mem_addr, bus0.o_mem_we, bus0.o_shift_en, bus0.o_busy, bus0.o_done};
   assign obs1 = {bus1.o_phase, bus1.o_dir, bus1.o_mem_addr, bus1.o_mem_we, bus1.o_shift_en, bus1.o_busy, bus1.o_done};
   assign obs2 = {bus2.o_phase, bus2.o_dir, bus2.o_mem_addr, bus2.o_mem_we, bus2.o_shift_en, bus2.o_busy, bus2.o_done};

   function automatic logic [11:0] obs_of(input int w);
      case (w)
         0:       return obs0;
         1:       return obs1;
         default: return obs2;
      endcase
   endfunction

   function automatic int busy_len(input int s, input int n, input int c);
      return 8 + ((s < 1) ? 1 : s) + 4 * n + ((c < 1) ? 1 : c) + 1;
   endfunction

   // Expected outputs on busy cycle i of a run (i counted from the LOAD entry edge)
   function automatic logic [11:0] exp_out(input int i, input int s, input int n, input int c);
      int se;
      int ce;
      int k;
      logic [2:0] a;
      logic [1:0] d;
      se = (s < 1) ? 1 : s;
      ce = (c < 1) ? 1 : c;
      if (i < 8) begin
         a = 3'(i);
         return {3'd1, 2'd0, a, 4'b1010};
      end else if (i < 8 + se) begin
         return {3'd2, 2'd0, 3'd0, 4'b0010};
      end else if (i < 8 + se + 4 * n) begin
         k = (i - 8 - se) / n;
         d = 2'(k);
         return {3'd3, d, 3'd0, 4'b0110};
      end else if (i < 8 + se + 4 * n + ce) begin
         return {3'd4, 2'd0, 3'd0, 4'b0010};
      end else if (i == 8 + se + 4 * n + ce) begin
         return {3'd5, 2'd0, 3'd0, 4'b0011};
      end
      return 12'd0;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      #1 rst = 1'b1;
      #2;
      for (int w = 0; w < 3; w++) begin
         checks++;
         if (obs_of(w) !== 12'd0) begin
            failures++;
            $display("FAIL reset_async dut%0d: got %h expected %h", w, obs_of(w), 12'd0);
         end
      end
      step();
      step();
      rst = 1'b0;
      step();
      for (int w = 0; w < 3; w++) begin
         checks++;
         if (obs_of(w) !== 12'd0) begin
            failures++;
            $display("FAIL reset_release dut%0d: got %h expected %h", w, obs_of(w), 12'd0);
         end
      end
      $display("reset: checked all DUTs idle");
   endtask

   // Single start pulse; optional extra start pulses in LOAD and in DONE that must be ignored
   task automatic test_run(input int w, input int s, input int n, input int c, input bit mid);
      int total;
      int busy_cnt;
      int done_cnt;
      logic [11:0] o;
      total = busy_len(s, n, c);
      busy_cnt = 0;
      done_cnt = 0;
      start_v[w] = 1'b1;
      for (int i = 0; i <= total + 1; i++) begin
         step();
         start_v[w] = mid && (i == 3 || i == total - 1);
         o = obs_of(w);
         busy_cnt += int'(o[1]);
         done_cnt += int'(o[0]);
         checks++;
         if (o !== exp_out(i, s, n, c)) begin
            failures++;
            $display("FAIL run_trace dut%0d cycle %0d: got %h expected %h", w, i, o, exp_out(i, s, n, c));
         end
      end
      start_v[w] = 1'b0;
      checks++;
      if (busy_cnt !== total) begin
         failures++;
         $display("FAIL busy_len dut%0d: got %0d expected %0d", w, busy_cnt, total);
      end
      checks++;
      if (done_cnt !== 1) begin
         failures++;
         $display("FAIL done_pulses dut%0d: got %0d expected %0d", w, done_cnt, 1);
      end
      $display("run dut%0d S=%0d N=%0d C=%0d: busy %0d cycles, done pulses %0d", w, s, n, c, busy_cnt, done_cnt);
   endtask

   task automatic test_halt(input int w, input int s, input int n, input int c, input int at);
      logic [11:0] o;
      int done_cnt;
      done_cnt = 0;
      start_v[w] = 1'b1;
      step();
      start_v[w] = 1'b0;
      for (int i = 1; i <= at; i++) step();
      o = obs_of(w);
      checks++;
      if (o !== exp_out(at, s, n, c)) begin
         failures++;
         $display("FAIL halt_pre dut%0d cycle %0d: got %h expected %h", w, at, o, exp_out(at, s, n, c));
      end
      halt_v[w] = 1'b1;
      step();
      halt_v[w] = 1'b0;
      o = obs_of(w);
      checks++;
      if (o !== 12'd0) begin
         failures++;
         $display("FAIL halt_idle dut%0d: got %h expected %h", w, o, 12'd0);
      end
      for (int i = 0; i < 12; i++) begin
         step();
         done_cnt += int'(obs_of(w) != 12'd0);
      end
      checks++;
      if (done_cnt !== 0) begin
         failures++;
         $display("FAIL halt_stays_idle dut%0d: got %0d non-idle cycles expected %0d", w, done_cnt, 0);
      end
      $display("halt dut%0d at cycle %0d: idle after halt", w, at);
   endtask

   task automatic test_start_halt_idle();
      start_v[0] = 1'b1;
      halt_v[0]  = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         checks++;
         if (obs0 !== 12'd0) begin
            failures++;
            $display("FAIL start_halt_idle cycle %0d: got %h expected %h", i, obs0, 12'd0);
         end
      end
      start_v[0] = 1'b0;
      halt_v[0]  = 1'b0;
      step();
      $display("start+halt in IDLE: stayed idle");
   endtask

   task automatic test_reset_mid();
      start_v[0] = 1'b1;
      step();
      start_v[0] = 1'b0;
      for (int i = 1; i <= 5; i++) step();
      checks++;
      if (obs0 !== exp_out(5, 1, 2, 1)) begin
         failures++;
         $display("FAIL reset_mid_pre: got %h expected %h", obs0, exp_out(5, 1, 2, 1));
      end
      #2 rst = 1'b1;
      #1;
      checks++;
      if (obs0 !== 12'd0) begin
         failures++;
         $display("FAIL reset_mid_async: got %h expected %h", obs0, 12'd0);
      end
      step();
      step();
      rst = 1'b0;
      for (int i = 0; i < 4; i++) begin
         step();
         checks++;
         if (obs0 !== 12'd0) begin
            failures++;
            $display("FAIL reset_mid_wait cycle %0d: got %h expected %h", i, obs0, 12'd0);
         end
      end
      $display("reset mid-LOAD: outputs cleared, waiting idle");
   endtask

   task automatic test_back_to_back();
      logic [11:0] e;
      int errs;
      errs = 0;
      start_v[0] = 1'b1;
      for (int j = 0; j <= 40; j++) begin
         step();
         if (j == 39) start_v[0] = 1'b0;
         if (j < 19)       e = exp_out(j, 1, 2, 1);
         else if (j == 19) e = 12'd0;
         else if (j < 39)  e = exp_out(j - 20, 1, 2, 1);
         else              e = 12'd0;
         checks++;
         if (obs0 !== e) begin
            failures++;
            errs++;
            $display("FAIL back_to_back cycle %0d: got %h expected %h", j, obs0, e);
         end
      end
      start_v[0] = 1'b0;
      $display("back-to-back: 41 cycles compared, %0d differences", errs);
   endtask

   initial begin
      test_reset();
      test_run(0, 1, 2, 1, 1'b1);
      test_run(1, 0, 0, 0, 1'b0);
      test_run(2, 3, 1, 2, 1'b1);
      test_halt(0, 1, 2, 1, 11);
      test_halt(2, 3, 1, 2, 2);
      test_start_halt_idle();
      test_reset_mid();
      test_back_to_back();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
